// File: rtl/ex_stage_md.sv
// Execute stage: single-cycle ALU/branch resolution plus an iterative
// multiply/divide unit that stalls decode, all results registered at EX/MEM.
module ex_stage_md #(
   parameter int XLEN = 32,
   parameter int RD_W = 5
) (
   input  logic            clk_i,
   input  logic            reset_i,
   input  logic            valid_i,
   input  logic            flush_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic [XLEN-1:0] read_data1_i,
   input  logic [XLEN-1:0] read_data2_i,
   input  logic [XLEN-1:0] offset_i,
   input  logic [RD_W-1:0] rd_i,
   input  logic [4:0]      aluop_i,
   input  logic            alusrc_i,
   output logic            stall_o,
   output logic            valid_o,
   output logic [XLEN-1:0] alu_result_o,
   output logic [XLEN-1:0] read_data2_o,
   output logic [RD_W-1:0] write_reg_o,
   output logic            branch_taken_o,
   output logic [XLEN-1:0] pc_ifbranch_o
);

   localparam int SHW = $clog2(XLEN);
   localparam int CW  = $clog2(XLEN);
   localparam logic [CW-1:0] LAST_CNT = CW'(XLEN - 1);

   localparam logic [4:0] OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_SLL = 5'd2,  OP_SLT = 5'd3;
   localparam logic [4:0] OP_SLTU = 5'd4, OP_XOR = 5'd5,  OP_SRL = 5'd6,  OP_SRA = 5'd7;
   localparam logic [4:0] OP_OR = 5'd8,   OP_AND = 5'd9,  OP_MUL = 5'd10, OP_MULH = 5'd11;
   localparam logic [4:0] OP_MULHSU = 5'd12, OP_MULHU = 5'd13, OP_DIV = 5'd14, OP_DIVU = 5'd15;
   localparam logic [4:0] OP_REM = 5'd16, OP_REMU = 5'd17, OP_BEQ = 5'd18, OP_BNE = 5'd19;
   localparam logic [4:0] OP_BLT = 5'd20, OP_BGE = 5'd21, OP_BLTU = 5'd22, OP_BGEU = 5'd23;

   typedef enum logic [0:0] {IDLE = 1'b0, BUSY = 1'b1} state_t;

   state_t            state_q, state_d;
   logic [CW-1:0]     count_q, count_d;
   logic [2*XLEN-1:0] acc_q, acc_d;
   logic [XLEN-1:0]   mcand_q, mcand_d;
   logic [XLEN-1:0]   dividend_q, dividend_d;
   logic [4:0]        op_q, op_d;
   logic              neg_q, neg_d, rem_neg_q, rem_neg_d, dz_q, dz_d;
   logic [RD_W-1:0]   rd_q, rd_d;
   logic [XLEN-1:0]   rs2_q, rs2_d, pcb_q, pcb_d;

   logic            valid_q;
   logic [XLEN-1:0] result_q, rd2_out_q, pc_out_q;
   logic [RD_W-1:0] wreg_q;
   logic            taken_q;

   logic [XLEN-1:0]   op_b_s, alu_res_s, md_res_s, a_mag_s, b_mag_s, quo_s, rem_s;
   logic [SHW-1:0]    shamt_s;
   logic              taken_s, is_md_s, is_mul_s, a_neg_s, b_neg_s;
   logic              start_s, accept_s, last_s;
   logic [XLEN:0]     mul_sum_s, div_shift_s, div_trial_s;
   logic [2*XLEN-1:0] acc_step_s, prod_s;

   assign op_b_s  = alusrc_i ? offset_i : read_data2_i;
   assign shamt_s = op_b_s[SHW-1:0];
   assign is_md_s = (aluop_i >= OP_MUL) && (aluop_i <= OP_REMU);
   assign start_s  = (state_q == IDLE) && valid_i && is_md_s && !flush_i;
   assign accept_s = (state_q == IDLE) && valid_i && !is_md_s && !flush_i;
   assign last_s   = (state_q == BUSY) && (count_q == LAST_CNT) && !flush_i;

   // Single-cycle ALU and branch comparison
   always_comb begin
      alu_res_s = {XLEN{1'b0}};
      taken_s   = 1'b0;
      case (aluop_i)
         OP_SUB:  alu_res_s = read_data1_i - op_b_s;
         OP_SLL:  alu_res_s = read_data1_i << shamt_s;
         OP_SLT:  alu_res_s = {{(XLEN-1){1'b0}}, $signed(read_data1_i) < $signed(op_b_s)};
         OP_SLTU: alu_res_s = {{(XLEN-1){1'b0}}, read_data1_i < op_b_s};
         OP_XOR:  alu_res_s = read_data1_i ^ op_b_s;
         OP_SRL:  alu_res_s = read_data1_i >> shamt_s;
         OP_SRA:  alu_res_s = $unsigned($signed(read_data1_i) >>> shamt_s);
         OP_OR:   alu_res_s = read_data1_i | op_b_s;
         OP_AND:  alu_res_s = read_data1_i & op_b_s;
         OP_BEQ:  taken_s = (read_data1_i == read_data2_i);
         OP_BNE:  taken_s = (read_data1_i != read_data2_i);
         OP_BLT:  taken_s = ($signed(read_data1_i) < $signed(read_data2_i));
         OP_BGE:  taken_s = ($signed(read_data1_i) >= $signed(read_data2_i));
         OP_BLTU: taken_s = (read_data1_i < read_data2_i);
         OP_BGEU: taken_s = (read_data1_i >= read_data2_i);
         OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU,
         OP_DIV, OP_DIVU, OP_REM, OP_REMU: alu_res_s = {XLEN{1'b0}};
         default: alu_res_s = read_data1_i + op_b_s;
      endcase
   end

   // Operand magnitudes: only the signed halves of each op honour the sign bit
   always_comb begin
      a_neg_s = read_data1_i[XLEN-1] &&
                ((aluop_i == OP_MULH) || (aluop_i == OP_MULHSU) ||
                 (aluop_i == OP_DIV) || (aluop_i == OP_REM));
      b_neg_s = op_b_s[XLEN-1] &&
                ((aluop_i == OP_MULH) || (aluop_i == OP_DIV) || (aluop_i == OP_REM));
      a_mag_s = a_neg_s ? (~read_data1_i + {{(XLEN-1){1'b0}}, 1'b1}) : read_data1_i;
      b_mag_s = b_neg_s ? (~op_b_s + {{(XLEN-1){1'b0}}, 1'b1}) : op_b_s;
   end

   // One shift-add or restoring-subtract iteration on the accumulator
   always_comb begin
      is_mul_s    = (op_q <= OP_MULHU);
      mul_sum_s   = {1'b0, acc_q[2*XLEN-1:XLEN]} +
                    (acc_q[0] ? {1'b0, mcand_q} : {(XLEN+1){1'b0}});
      div_shift_s = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
      div_trial_s = div_shift_s - {1'b0, mcand_q};
      if (is_mul_s) begin
         acc_step_s = {mul_sum_s, acc_q[XLEN-1:1]};
      end else if (!div_trial_s[XLEN]) begin
         acc_step_s = {div_trial_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
      end else begin
         acc_step_s = {div_shift_s[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      end
   end

   // Sign fix-up and special cases applied to the final iteration's value
   always_comb begin
      prod_s = neg_q ? (~acc_step_s + {{(2*XLEN-1){1'b0}}, 1'b1}) : acc_step_s;
      if (dz_q) begin
         quo_s = {XLEN{1'b1}};
         rem_s = dividend_q;
      end else begin
         quo_s = neg_q ? (~acc_step_s[XLEN-1:0] + {{(XLEN-1){1'b0}}, 1'b1})
                       : acc_step_s[XLEN-1:0];
         rem_s = rem_neg_q ? (~acc_step_s[2*XLEN-1:XLEN] + {{(XLEN-1){1'b0}}, 1'b1})
                           : acc_step_s[2*XLEN-1:XLEN];
      end
      case (op_q)
         OP_MUL:                       md_res_s = prod_s[XLEN-1:0];
         OP_MULH, OP_MULHSU, OP_MULHU: md_res_s = prod_s[2*XLEN-1:XLEN];
         OP_DIV, OP_DIVU:              md_res_s = quo_s;
         OP_REM, OP_REMU:              md_res_s = rem_s;
         default:                      md_res_s = {XLEN{1'b0}};
      endcase
   end

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state; flush always wins
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (start_s) state_d = BUSY;
            else         state_d = IDLE;
         end
         BUSY: begin
            if (flush_i || (count_q == LAST_CNT)) state_d = IDLE;
            else                                  state_d = BUSY;
         end
         default: state_d = IDLE;
      endcase
   end

   // FSM output: stall decode until the final iteration cycle
   always_comb begin
      if (flush_i) begin
         stall_o = 1'b0;
      end else if (state_q == IDLE) begin
         stall_o = valid_i && is_md_s;
      end else begin
         stall_o = (count_q != LAST_CNT);
      end
   end

   // MD operand capture and iteration next-state
   always_comb begin
      count_d = count_q;       acc_d = acc_q;         mcand_d = mcand_q;
      dividend_d = dividend_q; op_d = op_q;           neg_d = neg_q;
      rem_neg_d = rem_neg_q;   dz_d = dz_q;           rd_d = rd_q;
      rs2_d = rs2_q;           pcb_d = pcb_q;
      if (start_s) begin
         count_d    = {CW{1'b0}};
         op_d       = aluop_i;
         rd_d       = rd_i;
         rs2_d      = read_data2_i;
         pcb_d      = pc_i + offset_i;
         dividend_d = read_data1_i;
         neg_d      = a_neg_s ^ b_neg_s;
         rem_neg_d  = a_neg_s;
         dz_d       = (op_b_s == {XLEN{1'b0}}) && (aluop_i >= OP_DIV);
         if (aluop_i <= OP_MULHU) begin
            acc_d   = {{XLEN{1'b0}}, b_mag_s};
            mcand_d = a_mag_s;
         end else begin
            acc_d   = {{XLEN{1'b0}}, a_mag_s};
            mcand_d = b_mag_s;
         end
      end else if (state_q == BUSY) begin
         count_d = count_q + {{(CW-1){1'b0}}, 1'b1};
         acc_d   = acc_step_s;
      end else begin
         count_d = count_q;
      end
   end

   // MD datapath registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         count_q <= {CW{1'b0}};      acc_q <= {(2*XLEN){1'b0}};  mcand_q <= {XLEN{1'b0}};
         dividend_q <= {XLEN{1'b0}}; op_q <= 5'd0;               neg_q <= 1'b0;
         rem_neg_q <= 1'b0;          dz_q <= 1'b0;               rd_q <= {RD_W{1'b0}};
         rs2_q <= {XLEN{1'b0}};      pcb_q <= {XLEN{1'b0}};
      end else begin
         count_q <= count_d;         acc_q <= acc_d;             mcand_q <= mcand_d;
         dividend_q <= dividend_d;   op_q <= op_d;               neg_q <= neg_d;
         rem_neg_q <= rem_neg_d;     dz_q <= dz_d;               rd_q <= rd_d;
         rs2_q <= rs2_d;             pcb_q <= pcb_d;
      end
   end

   // EX/MEM boundary registers
   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         valid_q <= 1'b0;           result_q <= {XLEN{1'b0}};  rd2_out_q <= {XLEN{1'b0}};
         wreg_q <= {RD_W{1'b0}};    taken_q <= 1'b0;           pc_out_q <= {XLEN{1'b0}};
      end else if (flush_i) begin
         valid_q <= 1'b0;
      end else if (accept_s) begin
         valid_q <= 1'b1;           result_q <= alu_res_s;     rd2_out_q <= read_data2_i;
         wreg_q <= rd_i;            taken_q <= taken_s;        pc_out_q <= pc_i + offset_i;
      end else if (last_s) begin
         valid_q <= 1'b1;           result_q <= md_res_s;      rd2_out_q <= rs2_q;
         wreg_q <= rd_q;            taken_q <= 1'b0;           pc_out_q <= pcb_q;
      end else begin
         valid_q <= 1'b0;
      end
   end

   assign valid_o        = valid_q;
   assign alu_result_o   = result_q;
   assign read_data2_o   = rd2_out_q;
   assign write_reg_o    = wreg_q;
   assign branch_taken_o = taken_q;
   assign pc_ifbranch_o  = pc_out_q;

endmodule

// File: tb/tb_ex_stage_md.sv
// Self-checking bench for ex_stage_md: directed corner cases, randomized ops
// against an arithmetic reference model, flush/reset aborts and pipeline timing.
module tb_ex_stage_md;
   logic        clk_i = 1'b0;
   logic        reset_i, valid_i, flush_i, alusrc_i;
   logic [31:0] pc_i, read_data1_i, read_data2_i, offset_i;
   logic [4:0]  rd_i, aluop_i;
   logic        stall_o, valid_o, branch_taken_o;
   logic [31:0] alu_result_o, read_data2_o, pc_ifbranch_o;
   logic [4:0]  write_reg_o;

   int checks = 0;
   int errors = 0;

   ex_stage_md #(.XLEN(32), .RD_W(5)) dut (
      .clk_i(clk_i), .reset_i(reset_i), .valid_i(valid_i), .flush_i(flush_i),
      .pc_i(pc_i), .read_data1_i(read_data1_i), .read_data2_i(read_data2_i),
      .offset_i(offset_i), .rd_i(rd_i), .aluop_i(aluop_i), .alusrc_i(alusrc_i),
      .stall_o(stall_o), .valid_o(valid_o), .alu_result_o(alu_result_o),
      .read_data2_o(read_data2_o), .write_reg_o(write_reg_o),
      .branch_taken_o(branch_taken_o), .pc_ifbranch_o(pc_ifbranch_o)
   );

   always #5 clk_i = ~clk_i;

   // Reference: {branch_taken, result} from the ISA rules using 64-bit arithmetic
   function automatic logic [32:0] ref_exec(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] rs2);
      longint sa, sb, s2;
      logic [63:0] p;
      logic [31:0] r;
      logic t;
      sa = longint'($signed(a)); sb = longint'($signed(b)); s2 = longint'($signed(rs2));
      r = 32'd0; t = 1'b0; p = 64'd0;
      case (op)
         5'd1:  r = a - b;
         5'd2:  r = a << b[4:0];
         5'd3:  r = (sa < sb) ? 32'd1 : 32'd0;
         5'd4:  r = (a < b) ? 32'd1 : 32'd0;
         5'd5:  r = a ^ b;
         5'd6:  r = a >> b[4:0];
         5'd7:  begin p = sa >>> b[4:0]; r = p[31:0]; end
         5'd8:  r = a | b;
         5'd9:  r = a & b;
         5'd10: begin p = {32'd0, a} * {32'd0, b}; r = p[31:0]; end
         5'd11: begin p = sa * sb; r = p[63:32]; end
         5'd12: begin p = sa * longint'({32'd0, b}); r = p[63:32]; end
         5'd13: begin p = {32'd0, a} * {32'd0, b}; r = p[63:32]; end
         5'd14: if (b == 32'd0) r = 32'hFFFFFFFF; else begin p = sa / sb; r = p[31:0]; end
         5'd15: if (b == 32'd0) r = 32'hFFFFFFFF; else r = a / b;
         5'd16: if (b == 32'd0) r = a; else begin p = sa % sb; r = p[31:0]; end
         5'd17: if (b == 32'd0) r = a; else r = a % b;
         5'd18: t = (a == rs2);
         5'd19: t = (a != rs2);
         5'd20: t = (sa < s2);
         5'd21: t = (sa >= s2);
         5'd22: t = (a < rs2);
         5'd23: t = (a >= rs2);
         default: r = a + b;
      endcase
      return {t, r};
   endfunction

   task automatic drive(input logic [4:0] op, input logic [31:0] a, input logic [31:0] rs2,
                        input logic [31:0] off, input logic src, input logic [31:0] pc,
                        input logic [4:0] rd);
      valid_i = 1'b1; aluop_i = op; read_data1_i = a; read_data2_i = rs2;
      offset_i = off; alusrc_i = src; pc_i = pc; rd_i = rd;
   endtask

   // Single-cycle op: stall low, valid and full output bundle one cycle later
   task automatic run_alu(input string nm, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] rs2, input logic [31:0] off, input logic src,
                          input logic [31:0] pc, input logic [4:0] rd);
      logic [32:0] e;
      logic [102:0] exp_bus, got_bus;
      e = ref_exec(op, a, src ? off : rs2, rs2);
      drive(op, a, rs2, off, src, pc, rd);
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL %s stall: got %b want 0", nm, stall_o);
      end
      @(posedge clk_i); #1;
      valid_i = 1'b0;
      checks++;
      if (alu_result_o !== e[31:0]) begin
         errors++; $display("FAIL %s result op=%0d a=%h b=%h: got %h want %h",
                            nm, op, a, src ? off : rs2, alu_result_o, e[31:0]);
      end
      exp_bus = {1'b1, e[32], pc + off, rs2, rd};
      got_bus = {valid_o, branch_taken_o, pc_ifbranch_o, read_data2_o, write_reg_o};
      checks++;
      if (got_bus !== exp_bus) begin
         errors++; $display("FAIL %s {valid,taken,pcb,rs2,rd}: got %h want %h", nm, got_bus, exp_bus);
      end
      @(posedge clk_i); #1;
   endtask

   // Multi-cycle op: stall for 32 cycles, result valid in cycle 33
   task automatic run_md(input string nm, input logic [4:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] rd);
      logic [32:0] e;
      logic [70:0] exp_bus, got_bus;
      int bad_stall;
      int bad_valid;
      e = ref_exec(op, a, b, b);
      bad_stall = 0; bad_valid = 0;
      drive(op, a, b, 32'h40, 1'b0, 32'h1000, rd);
      for (int k = 0; k <= 32; k++) begin
         #1;
         if (stall_o !== (k < 32)) bad_stall++;
         if (k > 0 && valid_o !== 1'b0) bad_valid++;
         @(posedge clk_i); #1;
      end
      valid_i = 1'b0;
      #1;
      checks++;
      if (bad_stall != 0 || bad_valid != 0) begin
         errors++; $display("FAIL %s timing: bad stall cycles %0d, early valid cycles %0d want 0,0",
                            nm, bad_stall, bad_valid);
      end
      checks++;
      if (alu_result_o !== e[31:0]) begin
         errors++; $display("FAIL %s result op=%0d a=%h b=%h: got %h want %h",
                            nm, op, a, b, alu_result_o, e[31:0]);
      end
      exp_bus = {1'b1, 1'b0, 32'h1040, b, rd};
      got_bus = {valid_o, branch_taken_o, pc_ifbranch_o, read_data2_o, write_reg_o};
      checks++;
      if (got_bus !== exp_bus) begin
         errors++; $display("FAIL %s {valid,taken,pcb,rs2,rd}: got %h want %h", nm, got_bus, exp_bus);
      end
      @(posedge clk_i); #1;
      checks++;
      if (valid_o !== 1'b0) begin
         errors++; $display("FAIL %s valid pulse: got %b want 0", nm, valid_o);
      end
   endtask

   task automatic test_reset();
      reset_i = 1'b1; valid_i = 1'b0; flush_i = 1'b0; alusrc_i = 1'b0;
      pc_i = 32'd0; read_data1_i = 32'd0; read_data2_i = 32'd0; offset_i = 32'd0;
      rd_i = 5'd0; aluop_i = 5'd0;
      repeat (2) @(posedge clk_i);
      #1;
      checks++;
      if ({valid_o, stall_o, branch_taken_o, alu_result_o, read_data2_o, write_reg_o, pc_ifbranch_o} !== 104'd0) begin
         errors++; $display("FAIL reset outputs: got v=%b s=%b t=%b r=%h d=%h w=%h p=%h want all 0",
                            valid_o, stall_o, branch_taken_o, alu_result_o, read_data2_o, write_reg_o, pc_ifbranch_o);
      end
      reset_i = 1'b0;
   endtask

   task automatic test_alu_directed();
      run_alu("add_wrap", 5'd0, 32'd7, 32'hFFFFFFF9, 32'h0, 1'b0, 32'h0, 5'd3);
      run_alu("blt", 5'd20, 32'hFFFFFFFF, 32'd1, 32'h20, 1'b0, 32'h100, 5'd0);
      run_alu("bgeu_imm", 5'd23, 32'd1, 32'hFFFFFFFF, 32'h4, 1'b1, 32'h200, 5'd0);
      run_alu("sra_imm", 5'd7, 32'h80000000, 32'd0, 32'd35, 1'b1, 32'h0, 5'd9);
      run_alu("op31_add", 5'd31, 32'd100, 32'd23, 32'd0, 1'b0, 32'h0, 5'd1);
   endtask

   task automatic test_md_directed();
      run_md("mulh_min", 5'd11, 32'h80000000, 32'h80000000, 5'd4);
      run_md("mulhu_max", 5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd5);
      run_md("div_neg", 5'd14, 32'hFFFFFFF9, 32'd2, 5'd6);
      run_md("rem_neg", 5'd16, 32'hFFFFFFF9, 32'd2, 5'd7);
      run_md("divu_zero", 5'd15, 32'd5, 32'd0, 5'd8);
      run_md("rem_zero", 5'd16, 32'd5, 32'd0, 5'd9);
      run_md("div_ovf", 5'd14, 32'h80000000, 32'hFFFFFFFF, 5'd10);
      run_md("rem_ovf", 5'd16, 32'h80000000, 32'hFFFFFFFF, 5'd11);
      run_md("div_zero_neg", 5'd14, 32'hFFFFFFF0, 32'd0, 5'd12);
      run_md("mulhsu", 5'd12, 32'hFFFFFFFF, 32'hFFFFFFFF, 5'd13);
   endtask

   function automatic logic [31:0] pick_val();
      logic [31:0] v;
      case ($urandom_range(0, 7))
         0: v = 32'd0;
         1: v = 32'hFFFFFFFF;
         2: v = 32'h80000000;
         3: v = 32'd1;
         default: v = $urandom;
      endcase
      return v;
   endfunction

   task automatic test_random();
      logic [4:0] op;
      for (int i = 0; i < 80; i++) begin
         op = 5'($urandom_range(0, 31));
         if (op >= 5'd10 && op <= 5'd17) begin
            run_md("rand_md", op, pick_val(), pick_val(), 5'($urandom));
         end else begin
            run_alu("rand_alu", op, pick_val(), pick_val(), pick_val(), 1'($urandom),
                    $urandom, 5'($urandom));
         end
      end
   endtask

   task automatic test_flush();
      int late_valid;
      late_valid = 0;
      drive(5'd14, 32'd1000, 32'd7, 32'd0, 1'b0, 32'h0, 5'd2);
      repeat (10) @(posedge clk_i);
      #1;
      flush_i = 1'b1;
      #1;
      checks++;
      if (stall_o !== 1'b0) begin
         errors++; $display("FAIL flush stall: got %b want 0", stall_o);
      end
      @(posedge clk_i); #1;
      flush_i = 1'b0; valid_i = 1'b0;
      #1;
      checks++;
      if ({valid_o, stall_o} !== 2'b00) begin
         errors++; $display("FAIL flush after: got valid/stall %b%b want 00", valid_o, stall_o);
      end
      for (int k = 0; k < 35; k++) begin
         @(posedge clk_i); #1;
         if (valid_o !== 1'b0) late_valid++;
      end
      checks++;
      if (late_valid != 0) begin
         errors++; $display("FAIL flush late result: got %0d valid cycles want 0", late_valid);
      end
      run_alu("add_post_flush", 5'd0, 32'd11, 32'd22, 32'd0, 1'b0, 32'h0, 5'd1);
   endtask

   task automatic test_reset_mid_mul();
      run_alu("add_pre_reset", 5'd0, 32'd1, 32'd2, 32'h8, 1'b0, 32'h10, 5'd7);
      drive(5'd10, 32'd9, 32'd9, 32'd0, 1'b0, 32'h0, 5'd3);
      repeat (5) @(posedge clk_i);
      #1;
      reset_i = 1'b1; valid_i = 1'b0;
      @(posedge clk_i); #1;
      reset_i = 1'b0;
      #1;
      checks++;
      if ({valid_o, stall_o, branch_taken_o, alu_result_o, read_data2_o, write_reg_o, pc_ifbranch_o} !== 104'd0) begin
         errors++; $display("FAIL reset_mid_mul outputs: got v=%b s=%b r=%h d=%h w=%h p=%h want all 0",
                            valid_o, stall_o, alu_result_o, read_data2_o, write_reg_o, pc_ifbranch_o);
      end
      repeat (40) @(posedge clk_i);
      #1;
      checks++;
      if (valid_o !== 1'b0) begin
         errors++; $display("FAIL reset_mid_mul late result: got %b want 0", valid_o);
      end
   endtask

   // ADD at cycle 0, MUL held cycles 1..33, ADD at cycle 34
   task automatic test_back_to_back();
      logic exp_v, exp_s;
      logic [31:0] exp_r;
      for (int c = 0; c <= 37; c++) begin
         if (c == 0)                drive(5'd0, 32'd7, 32'hFFFFFFF9, 32'd0, 1'b0, 32'h0, 5'd1);
         else if (c <= 33)          drive(5'd10, 32'd3, 32'd5, 32'd0, 1'b0, 32'h0, 5'd2);
         else if (c == 34)          drive(5'd0, 32'd10, 32'd20, 32'd0, 1'b0, 32'h0, 5'd3);
         else                       valid_i = 1'b0;
         #1;
         exp_v = (c == 1) || (c == 34) || (c == 35);
         exp_s = (c >= 1) && (c <= 32);
         checks++;
         if ({valid_o, stall_o} !== {exp_v, exp_s}) begin
            errors++; $display("FAIL b2b cycle %0d valid/stall: got %b%b want %b%b",
                               c, valid_o, stall_o, exp_v, exp_s);
         end
         if (exp_v) begin
            exp_r = (c == 1) ? 32'd0 : ((c == 34) ? 32'd15 : 32'd30);
            checks++;
            if (alu_result_o !== exp_r) begin
               errors++; $display("FAIL b2b cycle %0d result: got %h want %h", c, alu_result_o, exp_r);
            end
         end
         @(posedge clk_i); #1;
      end
   endtask

   initial begin
      test_reset();
      test_alu_directed();
      test_md_directed();
      test_random();
      test_flush();
      test_reset_mid_mul();
      test_back_to_back();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
